game_timer_rng: RTL and testbench

Support block for the word-guessing game. It provides two services:
- A 60-second round timer on clk2 that drives a 10-LED progress bar and a sticky timeout flag.
- A free-running 4-bit LFSR on a separate fast clock that supplies the random word index.

The game FSM samples num when it starts a round and polls flag every clk2 cycle.

---
 rtl/game_pkg.sv | 16 +
 rtl/lfsr4.sv | 26 ++
 rtl/sec_timer.sv | 57 +++++
 rtl/game_timer_rng.sv | 35 +++
 tb/tb_game_timer_rng.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared constants for the word-game support block: timer defaults, LED bar size,
// LFSR seed, and a counter-width helper that never returns zero.
package game_pkg;

    localparam int             CLK_HZ_DEFAULT    = 50_000_000;
    localparam int             TIMEOUT_S_DEFAULT = 60;
    localparam int             LED_COUNT         = 10;
    localparam logic [3:0]     LFSR_SEED_DEFAULT = 4'b0001;
    localparam int             PRESC_W_DEFAULT   = $clog2(CLK_HZ_DEFAULT);

    // Width needed to hold 0..n-1, kept at least 1 so tiny test configs still elaborate.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lfsr4.sv
// Free-running 4-bit Fibonacci LFSR (x^4+x^3+1) on its own clock; no reset, powers up
// at the seed and reloads the seed if the all-zero lock-up state is ever reached.
module lfsr4
    import game_pkg::*;
#(
    parameter logic [3:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic       rng_clk,
    output logic [3:0] num
);

    logic [3:0] q_q = LFSR_SEED;
    logic [3:0] q_d;

    always_comb begin
        q_d = (q_q == 4'b0000) ? LFSR_SEED : {q_q[2:0], q_q[3] ^ q_q[2]};
    end

    always_ff @(posedge rng_clk) begin
        q_q <= q_d;
    end

    // Consumers on clk2 sample this without synchronisation; any value is a usable index.
    assign num = q_q;

endmodule

// File: rtl/sec_timer.sv
// Round timer: one-second prescaler, saturating seconds counter, thermometer LED bar
// and sticky timeout flag, all registered on clk2 with synchronous active-low reset.
module sec_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
    input  logic                 clk2,
    input  logic                 rst,
    output logic                 flag,
    output logic [LED_COUNT-1:0] led
);

    localparam int PW   = cnt_width(CLK_HZ);
    localparam int SW   = cnt_width(TIMEOUT_S + 1);
    localparam int STEP = TIMEOUT_S / LED_COUNT;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SEC_MAX   = SW'(TIMEOUT_S);

    logic [PW-1:0]        presc_q, presc_d;
    logic [SW-1:0]        sec_q, sec_d;
    logic                 flag_q, flag_d;
    logic [LED_COUNT-1:0] led_q, led_d;
    logic                 tick;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        sec_d   = (tick && (sec_q < SEC_MAX)) ? sec_q + 1'b1 : sec_q;
        // Outputs follow the next seconds value so they change on the same edge as sec.
        flag_d  = (sec_d == SEC_MAX);
        led_d   = '0;
        for (int i = 0; i < LED_COUNT; i++) begin
            led_d[i] = (32'(sec_d) >= 32'((i + 1) * STEP));
        end
    end

    always_ff @(posedge clk2) begin
        if (!rst) begin
            presc_q <= '0;
            sec_q   <= '0;
            flag_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            flag_q  <= flag_d;
            led_q   <= led_d;
        end
    end

    assign flag = flag_q;
    assign led  = led_q;

endmodule

// File: rtl/game_timer_rng.sv
// Support block for the word-guessing game: round timer on clk2 plus an independent
// LFSR on rng_clk that supplies the random word index.
module game_timer_rng
    import game_pkg::*;
#(
    parameter int         CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int         TIMEOUT_S = TIMEOUT_S_DEFAULT,
    parameter logic [3:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic                 clk2,
    input  logic                 rst,
    input  logic                 rng_clk,
    output logic                 flag,
    output logic [LED_COUNT-1:0] led,
    output logic [3:0]           num
);

    sec_timer #(
        .CLK_HZ    (CLK_HZ),
        .TIMEOUT_S (TIMEOUT_S)
    ) u_timer (
        .clk2 (clk2),
        .rst  (rst),
        .flag (flag),
        .led  (led)
    );

    lfsr4 #(
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .rng_clk (rng_clk),
        .num     (num)
    );

endmodule

// File: tb/tb_game_timer_rng.sv
// Scoreboard bench: stimulus pushes hand-computed expectations tagged with the clk2
// edge (or rng_clk edge order) they apply to; monitors pop and compare.
module tb_game_timer_rng;

    logic       clk2;
    logic       rst;
    logic       rng_clk;
    logic       flag;
    logic [9:0] led;
    logic [3:0] num;

    game_timer_rng #(
        .CLK_HZ    (4),
        .TIMEOUT_S (60),
        .LFSR_SEED (4'b0001)
    ) dut (
        .clk2    (clk2),
        .rst     (rst),
        .rng_clk (rng_clk),
        .flag    (flag),
        .led     (led),
        .num     (num)
    );

    typedef struct {
        int         cyc;
        logic [9:0] led;
        logic       flag;
        string      name;
    } texp_t;

    texp_t      tq[$];
    logic [3:0] rq[$];
    int         cyc;
    int         tests;
    int         failed;

    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    initial begin
        rng_clk = 1'b1;
        forever #7 rng_clk = ~rng_clk;
    end

    initial cyc = 0;
    always @(posedge clk2) cyc <= cyc + 1;

    // Timer monitor: after each clk2 rising edge, compare every expectation due now.
    initial begin
        texp_t e;
        forever begin
            @(negedge clk2);
            #1;
            while (tq.size() > 0 && tq[0].cyc <= cyc) begin
                e = tq.pop_front();
                tests++;
                if (e.cyc != cyc || led !== e.led || flag !== e.flag) begin
                    failed++;
                    $display("FAIL %s @edge %0d (now %0d): led=%h flag=%b, expected led=%h flag=%b",
                             e.name, e.cyc, cyc, led, flag, e.led, e.flag);
                end
            end
        end
    end

    // LFSR monitor: one expected num per rng_clk falling edge while entries are queued.
    initial begin
        logic [3:0] r;
        forever begin
            @(negedge rng_clk);
            #1;
            if (rq.size() > 0) begin
                r = rq.pop_front();
                tests++;
                if (num !== r) begin
                    failed++;
                    $display("FAIL lfsr_seq: num=%b expected %b", num, r);
                end
            end
        end
    end

    task automatic push_t(input int c, input logic [9:0] l, input logic f, input string n);
        texp_t e;
        e.cyc = c; e.led = l; e.flag = f; e.name = n;
        tq.push_back(e);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk2);
    endtask

    // LFSR stimulus: power-up sequence over two full periods, then lock-up recovery.
    initial begin
        logic [3:0] seq [15];
        seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        for (int k = 0; k < 31; k++) rq.push_back(seq[k % 15]);
        for (int k = 0; k < 200 && rq.size() > 0; k++) @(negedge rng_clk);
        #2;
        force dut.u_lfsr.q_q = 4'b0000;
        #1;
        release dut.u_lfsr.q_q;
        rq.push_back(4'b0001);
    end

    initial begin
        int r;
        tests  = 0;
        failed = 0;
        rst    = 1'b0;

        // Held in reset for two edges.
        push_t(1, 10'h000, 1'b0, "reset_e1");
        push_t(2, 10'h000, 1'b0, "reset_e2");
        wait_cyc(2);
        rst = 1'b1;
        r = cyc;
        push_t(r + 23,  10'h000, 1'b0, "pre_led0");
        push_t(r + 24,  10'h001, 1'b0, "led0_rise");
        push_t(r + 47,  10'h001, 1'b0, "pre_led1");
        push_t(r + 48,  10'h003, 1'b0, "led1_rise");
        push_t(r + 96,  10'h00F, 1'b0, "sec24");
        push_t(r + 99,  10'h00F, 1'b0, "pre_midrst");
        push_t(r + 100, 10'h000, 1'b0, "midrst");

        // One-edge reset pulse mid-count.
        wait_cyc(r + 99);
        rst = 1'b0;
        wait_cyc(r + 100);
        rst = 1'b1;
        r = cyc;
        push_t(r + 23,  10'h000, 1'b0, "re_pre_led0");
        push_t(r + 24,  10'h001, 1'b0, "re_led0_rise");
        push_t(r + 48,  10'h003, 1'b0, "re_led1_rise");
        push_t(r + 120, 10'h01F, 1'b0, "sec30");
        push_t(r + 239, 10'h1FF, 1'b0, "pre_timeout");
        push_t(r + 240, 10'h3FF, 1'b1, "timeout");
        for (int n = 241; n <= 400; n++) push_t(r + n, 10'h3FF, 1'b1, "sticky");

        // Reset after timeout clears everything; the round runs again in full.
        wait_cyc(r + 409);
        rst = 1'b0;
        push_t(cyc + 1, 10'h000, 1'b0, "post_to_rst");
        wait_cyc(r + 410);
        rst = 1'b1;
        r = cyc;
        push_t(r + 1,   10'h000, 1'b0, "restart_e1");
        push_t(r + 239, 10'h1FF, 1'b0, "re_pre_timeout");
        push_t(r + 240, 10'h3FF, 1'b1, "re_timeout");
        push_t(r + 260, 10'h3FF, 1'b1, "re_sticky");
        wait_cyc(r + 261);

        for (int k = 0; k < 2000 && (tq.size() > 0 || rq.size() > 0); k++) @(negedge clk2);
        #2;
        if (tq.size() > 0 || rq.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d timer and %0d lfsr expectations left, expected 0",
                     tq.size(), rq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
